// File: rtl/decoder_output_arbiter_pkg.sv
// Shared constants for the decoder output arbiter: frame size derived from
// the decoder grid geometry, the byte width, and the FSM state encoding.
package decoder_output_arbiter_pkg;

    localparam int BYTE_W = 8;

    // Decoder grid geometry; one correction round per U slice.
    localparam int GRID_WIDTH_X               = 4;
    localparam int GRID_WIDTH_Z               = 1;
    localparam int GRID_WIDTH_U               = 3;
    localparam int CORRECTION_COUNT_PER_ROUND = 11;

    // Number of whole bytes needed to carry a given number of bits.
    function automatic int bytes_for_bits(input int bits);
        return (bits + BYTE_W - 1) / BYTE_W;
    endfunction

    // Iteration count (1 byte) + cycle count (2 bytes) + correction bytes.
    localparam int DEFAULT_FRAME_BYTES =
        3 + GRID_WIDTH_U * bytes_for_bits(CORRECTION_COUNT_PER_ROUND);

    // FSM encoding, kept as plain vectors for legacy tool flows.
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_FORWARD = 1'b1;

endpackage

// File: rtl/decoder_output_arbiter_if.sv
// Byte-stream bundle between the decoder controllers, the arbiter and the host.
//
// Handshake: every stream uses strict valid/ready. A byte transfers in a cycle
// where both valid and ready are high at the rising clock edge. A source must
// not drop valid or change data while valid is high and ready is low; ready
// may change freely and is never required before valid is asserted.
interface decoder_output_arbiter_if
    import decoder_output_arbiter_pkg::*;
#(
    parameter int NUM_DECODERS = 4
);
    logic [BYTE_W*NUM_DECODERS-1:0] in_data;
    logic [NUM_DECODERS-1:0]        in_valid;
    logic [NUM_DECODERS-1:0]        in_ready;
    logic [BYTE_W-1:0]              out_data;
    logic                           out_valid;
    logic                           out_ready;

    // Arbiter side: sinks the decoder streams, sources the host stream.
    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    // Environment side: decoders plus host.
    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/decoder_output_arbiter_rr_arbiter.sv
// Combinational round-robin pick: rotate the request vector so the search
// starts just after the last grant, take the lowest set bit, rotate back.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] grant,
    output logic                 any
);
    localparam int IW = $clog2(N);

    int         start;
    int         enc;
    logic       found;
    logic [N-1:0] rot;

    // Rotate, priority-encode and map the winner back to its real index.
    always_comb begin
        start = int'(last) + 1;
        if (start >= N) start = start - N;
        rot   = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[(i + start) % N];
        end
        enc   = 0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rot[i] && !found) begin
                enc   = i;
                found = 1'b1;
            end
        end
        grant = IW'((start + enc) % N);
        any   = |req;
    end
endmodule

// File: rtl/decoder_output_arbiter.sv
// Frame-level round-robin merge of NUM_DECODERS byte streams onto one host
// link. A granted decoder owns the link for a whole frame; an optional
// header byte carrying the source index precedes each frame.
module decoder_output_arbiter
    import decoder_output_arbiter_pkg::*;
#(
    parameter int NUM_DECODERS = 4,
    parameter int FRAME_BYTES  = DEFAULT_FRAME_BYTES,
    parameter int ID_HEADER    = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    decoder_output_arbiter_if.master        link,
    input  logic [NUM_DECODERS-1:0]         enable_mask,
    output logic [$clog2(NUM_DECODERS)-1:0] grant_idx,
    output logic                            frame_active,
    output logic [15:0]                     frames_sent
);
    localparam int IW = $clog2(NUM_DECODERS);
    localparam int CW = $clog2(FRAME_BYTES + 1);

    logic [0:0]        state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [15:0]       frames_sent_q, frames_sent_d;
    logic              out_valid_q, out_valid_d;
    logic [BYTE_W-1:0] out_data_q, out_data_d;

    logic                    load_ok;
    logic                    accept;
    logic                    load;
    logic [BYTE_W-1:0]       load_byte;
    logic [NUM_DECODERS-1:0] req_vec;
    logic [IW-1:0]           arb_grant;
    logic                    arb_any;

    // The mask only matters for new grants, so it gates the request vector.
    assign req_vec = link.in_valid & enable_mask;
    assign load_ok = !out_valid_q || link.out_ready;

    rr_arbiter #(.N(NUM_DECODERS)) u_rr (
        .req   (req_vec),
        .last  (last_q),
        .grant (arb_grant),
        .any   (arb_any)
    );

    // Only the granted decoder sees ready, and only while the output can take a byte.
    always_comb begin
        link.in_ready = '0;
        if (state_q == ST_FORWARD) begin
            link.in_ready[grant_q] = load_ok;
        end
    end

    assign accept = (state_q == ST_FORWARD) && link.in_valid[grant_q] && load_ok;

    // Next-state logic for the FSM, counters and the one-entry output register.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        frames_sent_d = frames_sent_q;
        load          = 1'b0;
        load_byte     = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any && load_ok) begin
                    grant_d = arb_grant;
                    cnt_d   = '0;
                    state_d = ST_FORWARD;
                    if (ID_HEADER != 0) begin
                        load      = 1'b1;
                        load_byte = BYTE_W'(arb_grant);
                    end
                end
            end
            default: begin
                if (accept) begin
                    load      = 1'b1;
                    load_byte = link.in_data[int'(grant_q)*BYTE_W +: BYTE_W];
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q == CW'(FRAME_BYTES - 1)) begin
                        state_d       = ST_IDLE;
                        frames_sent_d = frames_sent_q + 16'd1;
                        last_d        = grant_q;
                    end
                end
            end
        endcase

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = load_byte;
        end else if (link.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset makes decoder 0 the first round-robin winner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            last_q        <= IW'(NUM_DECODERS - 1);
            cnt_q         <= '0;
            frames_sent_q <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            frames_sent_q <= frames_sent_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

    assign link.out_valid = out_valid_q;
    assign link.out_data  = out_data_q;
    assign grant_idx      = grant_q;
    // Two-state FSM: frame_active is the state itself.
    assign frame_active   = (state_q == ST_FORWARD);
    assign frames_sent    = frames_sent_q;

endmodule

// File: tb/tb_decoder_output_arbiter.sv
// Directed bench for decoder_output_arbiter: per-decoder byte queues feed the
// inputs, a monitor captures every host transfer, and captured streams are
// compared against hand-built expected byte sequences.
module tb_decoder_output_arbiter;
    localparam int N  = 4;
    localparam int FB = 9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]  enable_mask;
    logic [1:0]    grant_idx;
    logic          frame_active;
    logic [15:0]   frames_sent;

    decoder_output_arbiter_if #(.NUM_DECODERS(N)) link ();

    decoder_output_arbiter #(.NUM_DECODERS(N), .FRAME_BYTES(FB), .ID_HEADER(1)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .link         (link),
        .enable_mask  (enable_mask),
        .grant_idx    (grant_idx),
        .frame_active (frame_active),
        .frames_sent  (frames_sent)
    );

    // ---------------- scoreboard state ----------------
    typedef logic [7:0] byte_q_t [$];
    byte_q_t     src_q [N];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int          got_t [$];
    logic        fa_q [$];
    bit          rec_fa = 1'b0;
    int          cyc = 0;
    logic [N-1:0] ready_seen = '0;
    logic [N-1:0] drv_fire;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && link.out_valid && link.out_ready) begin
            got_q.push_back(link.out_data);
            got_t.push_back(cyc);
        end
        ready_seen = ready_seen | link.in_ready;
    end

    always @(negedge clk) begin
        if (rec_fa) fa_q.push_back(frame_active);
    end

    // ---------------- decoder drivers ----------------
    task automatic drive_src();
        for (int g = 0; g < N; g++) begin
            link.in_valid[g] = (src_q[g].size() > 0);
            link.in_data[8*g +: 8] = (src_q[g].size() > 0) ? src_q[g][0] : 8'h00;
        end
    endtask

    always @(posedge clk) begin
        drv_fire = link.in_valid & link.in_ready;
        #2;
        for (int g = 0; g < N; g++) begin
            if (drv_fire[g] && src_q[g].size() > 0) void'(src_q[g].pop_front());
        end
        drive_src();
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] pat(input int g, input int f, input int k);
        return 8'(g * 32 + f * 16 + k);
    endfunction

    task automatic push_frame(input int g, input int f);
        for (int k = 0; k < FB; k++) src_q[g].push_back(pat(g, f, k));
    endtask

    task automatic exp_frame(input int g, input int f);
        exp_q.push_back(8'(g));
        for (int k = 0; k < FB; k++) exp_q.push_back(pat(g, f, k));
    endtask

    task automatic wait_got(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        if (got_q.size() < n) check({tag, "_timeout"}, got_q.size(), n);
    endtask

    task automatic compare_stream(input string tag);
        int m;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    task automatic flush_all();
        for (int g = 0; g < N; g++) src_q[g].delete();
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush_all();
        tick(2);
        rst_n = 1'b1;
        ready_seen = '0;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] t1_bytes [FB];
    int         gaps [$];
    int         run_len;
    bit         seen_hi;

    initial begin
        enable_mask    = '1;
        link.out_ready = 1'b1;
        link.in_valid  = '0;
        link.in_data   = '0;

        // Reset values
        tick(2);
        @(negedge clk);
        check("rst_out_valid", link.out_valid, 0);
        check("rst_out_data", link.out_data, 0);
        check("rst_in_ready", link.in_ready, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_frame_active", frame_active, 0);
        check("rst_frames_sent", frames_sent, 0);
        tick(1);
        rst_n = 1'b1;
        ready_seen = '0;

        // Single decoder frame from decoder 2
        t1_bytes = '{8'h05, 8'h00, 8'h1C, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        exp_q.push_back(8'h02);
        for (int k = 0; k < FB; k++) begin
            src_q[2].push_back(t1_bytes[k]);
            exp_q.push_back(t1_bytes[k]);
        end
        wait_got(10, 100, "single");
        tick(2);
        if (got_t.size() >= 10) check("single_contiguous", got_t[9] - got_t[0], 9);
        compare_stream("single");
        check("single_frames_sent", frames_sent, 1);
        check("single_ready_bits", ready_seen, 4'b0100);

        // All four decoders valid: rotation 0,1,2,3,0 with one idle cycle per frame
        do_reset();
        push_frame(0, 0); push_frame(1, 0); push_frame(2, 0); push_frame(3, 0); push_frame(0, 1);
        exp_frame(0, 0); exp_frame(1, 0); exp_frame(2, 0); exp_frame(3, 0); exp_frame(0, 1);
        fa_q.delete();
        rec_fa = 1'b1;
        wait_got(50, 300, "rr");
        tick(2);
        rec_fa = 1'b0;
        if (got_t.size() >= 50) check("rr_contiguous", got_t[49] - got_t[0], 49);
        compare_stream("rr");
        gaps.delete();
        run_len = 0;
        seen_hi = 1'b0;
        foreach (fa_q[i]) begin
            if (fa_q[i]) begin
                if (seen_hi && run_len > 0) gaps.push_back(run_len);
                seen_hi = 1'b1;
                run_len = 0;
            end else if (seen_hi) begin
                run_len++;
            end
        end
        check("rr_gap_count", gaps.size(), 4);
        foreach (gaps[i]) check($sformatf("rr_gap%0d", i), gaps[i], 1);
        check("rr_last_grant", grant_idx, 0);
        check("rr_frames_sent", frames_sent, 5);

        // Host backpressure for 3 cycles mid-frame
        do_reset();
        push_frame(1, 0);
        exp_frame(1, 0);
        wait_got(4, 50, "bp");
        link.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check($sformatf("bp_hold_data%0d", s), link.out_data, exp_q[4]);
            check($sformatf("bp_hold_valid%0d", s), link.out_valid, 1);
            check($sformatf("bp_in_ready%0d", s), link.in_ready, 0);
        end
        @(posedge clk);
        #1;
        link.out_ready = 1'b1;
        wait_got(10, 50, "bp");
        tick(2);
        compare_stream("bp");

        // enable_mask cleared while decoder 1 is mid-frame
        do_reset();
        push_frame(0, 0); push_frame(0, 1); push_frame(1, 0); push_frame(1, 1);
        push_frame(2, 0); push_frame(3, 0);
        exp_frame(0, 0); exp_frame(1, 0); exp_frame(2, 0); exp_frame(3, 0);
        exp_frame(0, 1); exp_frame(1, 1);
        wait_got(14, 100, "mask");
        check("mask_grant_mid", grant_idx, 1);
        enable_mask = 4'b1101;
        wait_got(50, 300, "mask");
        tick(20);
        check("mask_blocked_len", got_q.size(), 50);
        check("mask_blocked_idle", frame_active, 0);
        enable_mask = 4'b1111;
        wait_got(60, 100, "mask");
        tick(2);
        compare_stream("mask");
        check("mask_frames_sent", frames_sent, 6);

        // Reset mid-frame, then decoder 0 beats decoder 3
        push_frame(2, 0);
        wait_got(5, 50, "rstmid");
        rst_n = 1'b0;
        #2;
        check("rstmid_out_valid", link.out_valid, 0);
        check("rstmid_out_data", link.out_data, 0);
        check("rstmid_in_ready", link.in_ready, 0);
        check("rstmid_grant_idx", grant_idx, 0);
        check("rstmid_frame_active", frame_active, 0);
        check("rstmid_frames_sent", frames_sent, 0);
        flush_all();
        tick(2);
        rst_n = 1'b1;
        push_frame(3, 0); push_frame(0, 0);
        exp_frame(0, 0); exp_frame(3, 0);
        wait_got(20, 100, "rstmid");
        tick(2);
        compare_stream("rstmid");

        // frames_sent wraps from 65535 to 0
        force dut.frames_sent_q = 16'hFFFF;
        tick(1);
        release dut.frames_sent_q;
        tick(1);
        check("wrap_preload", frames_sent, 16'hFFFF);
        push_frame(1, 1);
        exp_frame(1, 1);
        wait_got(10, 60, "wrap");
        tick(2);
        check("wrap_frames_sent", frames_sent, 0);
        compare_stream("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
